// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID skid register and its perf counters.
package if_id_pkg;

  localparam int unsigned IF_ID_DATA_W = 32;
  localparam logic [IF_ID_DATA_W-1:0] IF_ID_NOP_INSTN = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [IF_ID_DATA_W-1:0] instn;
    logic [IF_ID_DATA_W-1:0] pc;
    logic [IF_ID_DATA_W-1:0] nextpc;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_perf_counters.sv
// Stall-cycle and flushed-entry counters for the IF/ID skid register (IF_ID_PERF_EN builds only).
module if_id_perf_counters
  import if_id_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  state_t      state,
  input  logic        id_stall,
  input  logic        flush,
  input  logic        in_valid,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushed_entries
);

  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] buffered;

  // Occupancy implied by the state encoding.
  always_comb begin
    buffered = '0;
    case (state)
      ONE:     buffered = CNT_W'(1);
      TWO:     buffered = CNT_W'(2);
      default: buffered = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles    <= '0;
      perf_flushed_entries <= '0;
    end else begin
      if ((state != EMPTY) && id_stall)
        perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
      if (flush)
        perf_flushed_entries <= perf_flushed_entries + buffered + CNT_W'(in_valid);
    end
  end

endmodule

// File: rtl/if_id_skid_register.sv
// IF/ID pipeline register with a two-entry skid buffer and branch flush.
// Optional performance counters are enabled with `define IF_ID_PERF_EN.
module if_id_skid_register
  import if_id_pkg::*;
#(
  parameter int unsigned        DATA_W    = IF_ID_DATA_W,
  parameter logic [DATA_W-1:0]  NOP_INSTN = DATA_W'(IF_ID_NOP_INSTN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inp_instn,
  input  logic [DATA_W-1:0] nextpc,
  input  logic [DATA_W-1:0] pc_to_branch,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              id_stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instn,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_nextpc
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flushed_entries
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] instn;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] nextpc;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_entry;
  logic   push;
  logic   pop;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & ~id_stall;
  assign in_entry  = '{instn: inp_instn, pc: pc_to_branch, nextpc: nextpc};

  // Head instn is forced to NOP whenever the buffer empties, so it can drive out_instn directly.
  assign out_instn  = head_q.instn;
  assign out_pc     = head_q.pc;
  assign out_nextpc = head_q.nextpc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '{instn: NOP_INSTN, pc: '0, nextpc: '0};
      tail_q  <= '{instn: NOP_INSTN, pc: '0, nextpc: '0};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d      = EMPTY;
      head_d.instn = NOP_INSTN;
      tail_d.instn = NOP_INSTN;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = in_entry;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            tail_d  = in_entry;
          end else if (pop && !push) begin
            state_d      = EMPTY;
            head_d.instn = NOP_INSTN;
          end else if (push && pop) begin
            head_d = in_entry;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
          end
        end
        default: begin
          state_d      = EMPTY;
          head_d.instn = NOP_INSTN;
          tail_d.instn = NOP_INSTN;
        end
      endcase
    end
  end

`ifdef IF_ID_PERF_EN
  if_id_perf_counters u_perf (
    .clk                  (clk),
    .reset                (reset),
    .state                (state_q),
    .id_stall             (id_stall),
    .flush                (flush),
    .in_valid             (in_valid),
    .perf_stall_cycles    (perf_stall_cycles),
    .perf_flushed_entries (perf_flushed_entries)
  );
`endif

endmodule

// File: tb/tb_if_id_skid_register.sv
// Directed scoreboard bench for if_id_skid_register (perf checks when IF_ID_PERF_EN is defined).
module tb_if_id_skid_register;
  import if_id_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] inp_instn;
  logic [31:0] nextpc;
  logic [31:0] pc_to_branch;
  logic        in_valid;
  logic        in_ready;
  logic        id_stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_instn;
  logic [31:0] out_pc;
  logic [31:0] out_nextpc;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushed_entries;
`endif

  if_id_skid_register dut (
    .clk          (clk),
    .reset        (reset),
    .inp_instn    (inp_instn),
    .nextpc       (nextpc),
    .pc_to_branch (pc_to_branch),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .id_stall     (id_stall),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_instn    (out_instn),
    .out_pc       (out_pc),
    .out_nextpc   (out_nextpc)
`ifdef IF_ID_PERF_EN
    ,
    .perf_stall_cycles    (perf_stall_cycles),
    .perf_flushed_entries (perf_flushed_entries)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  vectors;
  int unsigned  miscompares;
  if_id_entry_t sb[$];
  logic [31:0]  stall_m;
  logic [31:0]  flushed_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Check visible outputs against the model, then apply one clock of the given inputs.
  task automatic step(input logic v, input logic [31:0] instn, input logic [31:0] pc,
                      input logic st, input logic fl);
    if_id_entry_t e;
    int unsigned  n;
    in_valid     = v;
    inp_instn    = instn;
    pc_to_branch = pc;
    nextpc       = pc + 32'd4;
    id_stall     = st;
    flush        = fl;
    #1;
    n = sb.size();
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("in_ready", 32'(in_ready), 32'(n < 2));
    if (n != 0) begin
      chk("out_instn", out_instn, sb[0].instn);
      chk("out_pc", out_pc, sb[0].pc);
      chk("out_nextpc", out_nextpc, sb[0].nextpc);
    end else begin
      chk("out_instn_nop", out_instn, IF_ID_NOP_INSTN);
    end
`ifdef IF_ID_PERF_EN
    chk("perf_stall", perf_stall_cycles, stall_m);
    chk("perf_flushed", perf_flushed_entries, flushed_m);
`endif
    if (n != 0 && st) stall_m = stall_m + 32'd1;
    if (fl) begin
      flushed_m = flushed_m + 32'(n) + 32'(v);
      sb.delete();
    end else begin
      if (n != 0 && !st) void'(sb.pop_front());
      if (v && n < 2) begin
        e.instn  = instn;
        e.pc     = pc;
        e.nextpc = pc + 32'd4;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic st);
    step(1'b0, 32'h0, 32'h0, st, 1'b0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; stall_m = '0; flushed_m = '0;
    reset = 1'b1; in_valid = 1'b0; inp_instn = '0; nextpc = '0; pc_to_branch = '0;
    id_stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_instn", out_instn, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_nextpc", out_nextpc, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single push into EMPTY appears the next cycle
    step(1'b1, 32'h2008_0005, 32'd0, 1'b0, 1'b0);
    chk("lat_instn", out_instn, 32'h2008_0005);
    chk("lat_nextpc", out_nextpc, 32'd4);
    idle(1'b0);
    idle(1'b0);

    // Back-to-back stream with no stall
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h1000_0000 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Stall fills the skid buffer; fetch holds pc 8 until accepted
    step(1'b1, 32'hA000_0000, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'hA000_0004, 32'd4, 1'b1, 1'b0);
    step(1'b1, 32'hA000_0008, 32'd8, 1'b1, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'hA000_0008, 32'd8, 1'b1, 1'b0);
    step(1'b1, 32'hA000_0008, 32'd8, 1'b0, 1'b0);
    step(1'b1, 32'hA000_0008, 32'd8, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Flush from TWO with an incoming entry
    step(1'b1, 32'hB000_0000, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'hB000_0004, 32'd4, 1'b1, 1'b0);
    step(1'b1, 32'hB000_0010, 32'd16, 1'b1, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_instn", out_instn, 32'h0);
`ifdef IF_ID_PERF_EN
    chk("flush_count3", perf_flushed_entries, 32'd3);
`endif
    idle(1'b0);

    // Flush wins over a simultaneous push and pop
    step(1'b1, 32'hC000_0000, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'hC000_0004, 32'd4, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b1, 32'hC000_0008, 32'd8, 1'b0, 1'b0);
    idle(1'b0);

    // Asynchronous reset mid-stream
    step(1'b1, 32'hD000_0000, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'hD000_0004, 32'd4, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_instn", out_instn, 32'h0);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_out_nextpc", out_nextpc, 32'h0);
    sb.delete();
    stall_m = '0;
    flushed_m = '0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 32'hE000_0000, 32'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
